// File: rtl/sipo_deser.sv
// ---------------------------------------------------------------------------
// sipo_deser -- serial-to-parallel deserializer
//
// Sits directly behind a single-bit flip-flop stage and gathers its registered
// serial output into WIDTH-bit words. Each finished word is offered on a
// valid/ready handshake with one word of buffering. A word that finishes while
// the buffer is still full and not being taken is dropped, and a sticky
// overrun flag records the loss.
//
// Optional build macro:
//   PARITY_EN  each frame is WIDTH data bits followed by one even-parity bit.
//              parity_err reports a bad frame together with its word. Without
//              the macro a frame is WIDTH bits and parity_err is always 0.
//
// Parameters:
//   WIDTH      data bits per word (2..32)
//   MSB_FIRST  1: the first received bit lands in dout[WIDTH-1]
//              0: the first received bit lands in dout[0]
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   din         serial data bit from the upstream flip-flop
//   din_valid   bit strobe; din is taken only when high (no backpressure)
//   dout        assembled word (registered)
//   dout_valid  dout holds a word that has not been consumed
//   dout_ready  consumer takes dout when dout_valid and dout_ready are high
//   overrun     sticky: a completed word was dropped (cleared only by reset)
//   parity_err  parity result for the word on dout (PARITY_EN builds only)
// ---------------------------------------------------------------------------
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             parity_err
);

  // Frame length in bits: the data bits plus the parity bit when enabled.
`ifdef PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  localparam int            CW       = $clog2(FL);
  localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);

  // Even parity check over a frame: 1 when the total count of ones is odd.
  function automatic logic calc_parity_err(input logic [WIDTH-1:0] word,
                                           input logic             pbit);
    return (^word) ^ pbit;
  endfunction

  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             overrun_r;
  logic             parity_err_r;

  logic [WIDTH-1:0] shifted_s;
  logic             data_bit_s;
  logic             complete_s;
  logic [WIDTH-1:0] word_s;
  logic             word_perr_s;

  logic [WIDTH-1:0] shift_next_s;
  logic [CW-1:0]    bit_cnt_next_s;
  logic [WIDTH-1:0] dout_next_s;
  logic             dout_valid_next_s;
  logic             overrun_next_s;
  logic             parity_err_next_s;

  // Shift register contents after taking din in the configured direction.
  always_comb begin
    shifted_s = shift_r;
    if (MSB_FIRST) begin
      shifted_s = {shift_r[WIDTH-2:0], din};
    end else begin
      shifted_s = {din, shift_r[WIDTH-1:1]};
    end
  end

  // Frame bookkeeping: which accepted bits are data and which bit ends a frame.
  always_comb begin
    complete_s = din_valid && (bit_cnt_r == LAST_BIT);
`ifdef PARITY_EN
    // The trailing parity bit is checked but never shifted into the word,
    // so at completion the shift register already holds the full word.
    data_bit_s  = din_valid && (bit_cnt_r != LAST_BIT);
    word_s      = shift_r;
    word_perr_s = calc_parity_err(shift_r, din);
`else
    // The final data bit completes the word on the same edge it is sampled,
    // so the word is taken from the shift path rather than the register.
    data_bit_s  = din_valid;
    word_s      = shifted_s;
    word_perr_s = 1'b0;
`endif
  end

  // Next state of the shift register and the in-frame bit counter.
  always_comb begin
    shift_next_s   = shift_r;
    bit_cnt_next_s = bit_cnt_r;
    if (data_bit_s) begin
      shift_next_s = shifted_s;
    end else begin
      shift_next_s = shift_r;
    end
    if (!din_valid) begin
      bit_cnt_next_s = bit_cnt_r;
    end else if (complete_s) begin
      // Wrap straight into the next frame; there is no idle bit between words.
      bit_cnt_next_s = '0;
    end else begin
      bit_cnt_next_s = bit_cnt_r + CW'(1);
    end
  end

  // Next state of the one-word output slot and the sticky overrun flag.
  always_comb begin
    dout_next_s       = dout_r;
    dout_valid_next_s = dout_valid_r;
    overrun_next_s    = overrun_r;
    parity_err_next_s = parity_err_r;
    if (complete_s) begin
      if (!dout_valid_r || dout_ready) begin
        // Slot empty, or its word is consumed on this very edge: refill it.
        dout_next_s       = word_s;
        parity_err_next_s = word_perr_s;
        dout_valid_next_s = 1'b1;
      end else begin
        // Slot full and held: keep the old word stable and drop the new one.
        overrun_next_s = 1'b1;
      end
    end else if (dout_valid_r && dout_ready) begin
      dout_valid_next_s = 1'b0;
    end else begin
      dout_valid_next_s = dout_valid_r;
    end
  end

  // State registers; reset overrides any word completing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      shift_r      <= shift_next_s;
      bit_cnt_r    <= bit_cnt_next_s;
      dout_r       <= dout_next_s;
      dout_valid_r <= dout_valid_next_s;
      overrun_r    <= overrun_next_s;
      parity_err_r <= parity_err_next_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign overrun    = overrun_r;
  assign parity_err = parity_err_r;

endmodule

// File: tb/tb_sipo_deser.sv
// Testbench for sipo_deser: a word-level vector table plus hand sequences for
// gaps, mid-word reset, LSB-first ordering and (with PARITY_EN) parity errors.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b0;

  logic [7:0] dout_m;
  logic       dout_valid_m;
  logic       overrun_m;
  logic       parity_err_m;
  logic [7:0] dout_l;
  logic       dout_valid_l;
  logic       overrun_l;
  logic       parity_err_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .overrun(overrun_m), .parity_err(parity_err_m));

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .overrun(overrun_l), .parity_err(parity_err_l));

  typedef enum logic [1:0] {ACT_RESET, ACT_WORD, ACT_DRAIN} act_t;

  typedef struct {
    act_t       act;
    logic [7:0] word;
    logic       ready_last;
    logic [7:0] exp_dout;
    logic       exp_valid;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic drive_bit(input logic b, input logic v, input logic rdy);
    din = b;
    din_valid = v;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // MSB-first bit stream of word, plus a parity bit when enabled.
  // dout_ready is raised only together with the final bit of the frame.
  task automatic send_frame(input logic [7:0] word, input logic pbit, input logic ready_last);
    for (int i = 7; i >= 0; i--) begin
`ifdef PARITY_EN
      drive_bit(word[i], 1'b1, 1'b0);
`else
      drive_bit(word[i], 1'b1, (i == 0) ? ready_last : 1'b0);
`endif
    end
`ifdef PARITY_EN
    drive_bit(pbit, 1'b1, ready_last);
`endif
    din_valid = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] word, input logic ready_last);
    send_frame(word, ^word, ready_last);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    drive_bit(1'b0, 1'b0, 1'b1);
    dout_ready = 1'b0;
  endtask

  initial begin
    logic early_valid;
    logic [7:0] gap_word;

    vecs[0]  = '{ACT_RESET, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{ACT_WORD,  8'hA5, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[2]  = '{ACT_DRAIN, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{ACT_WORD,  8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[4]  = '{ACT_WORD,  8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0};
    vecs[5]  = '{ACT_DRAIN, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0};
    vecs[6]  = '{ACT_WORD,  8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
    vecs[7]  = '{ACT_WORD,  8'h22, 1'b0, 8'h11, 1'b1, 1'b1};
    vecs[8]  = '{ACT_DRAIN, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[9]  = '{ACT_WORD,  8'h5A, 1'b0, 8'h5A, 1'b1, 1'b1};
    vecs[10] = '{ACT_RESET, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{ACT_WORD,  8'h80, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[12] = '{ACT_DRAIN, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0};

    @(posedge clk);
    #1;

    // Word-level vector table (MSB-first instance).
    for (int r = 0; r < 13; r++) begin
      case (vecs[r].act)
        ACT_RESET: do_reset();
        ACT_WORD:  send_word(vecs[r].word, vecs[r].ready_last);
        default:   drain();
      endcase
      check($sformatf("row%0d dout", r), 32'(dout_m), 32'(vecs[r].exp_dout));
      check($sformatf("row%0d dout_valid", r), 32'(dout_valid_m), 32'(vecs[r].exp_valid));
      check($sformatf("row%0d overrun", r), 32'(overrun_m), 32'(vecs[r].exp_ovr));
      check($sformatf("row%0d parity_err", r), 32'(parity_err_m), 32'h0);
    end

    // 0x0F with random idle gaps; din toggles randomly while din_valid=0.
    gap_word = 8'h0F;
    early_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        early_valid = early_valid | dout_valid_m;
      end
      drive_bit(gap_word[i], 1'b1, 1'b0);
`ifndef PARITY_EN
      if (i != 0) early_valid = early_valid | dout_valid_m;
`else
      early_valid = early_valid | dout_valid_m;
`endif
    end
`ifdef PARITY_EN
    drive_bit(1'b0, 1'b1, 1'b0);
`endif
    din_valid = 1'b0;
    check("gaps early valid", 32'(early_valid), 32'h0);
    check("gaps dout", 32'(dout_m), 32'h0F);
    check("gaps dout_valid", 32'(dout_valid_m), 32'h1);
    drive_bit(1'b0, 1'b0, 1'b0);
    check("gaps idle hold", 32'(dout_m), 32'h0F);
    drain();

    // Partial word of ones, then reset, then a clean 0x81.
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    drive_bit(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check("midreset dout", 32'(dout_m), 32'h00);
    send_word(8'h81, 1'b0);
    check("midreset new word", 32'(dout_m), 32'h81);
    check("midreset valid", 32'(dout_valid_m), 32'h1);
    drain();

    // LSB-first instance sees the same stream.
    do_reset();
    send_word(8'hA5, 1'b0);
    check("lsb A5 dout", 32'(dout_l), 32'hA5);
    check("lsb A5 valid", 32'(dout_valid_l), 32'h1);
    drain();
    send_word(8'hC0, 1'b0);
    check("msb C0 dout", 32'(dout_m), 32'hC0);
    check("lsb 03 dout", 32'(dout_l), 32'h03);
    drain();

`ifdef PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b0);
    check("parity good perr", 32'(parity_err_m), 32'h0);
    drain();
    send_frame(8'hA5, 1'b1, 1'b0);
    check("parity bad perr", 32'(parity_err_m), 32'h1);
    check("parity bad dout", 32'(dout_m), 32'hA5);
    send_frame(8'h3C, 1'b0, 1'b0);
    check("parity drop keeps perr", 32'(parity_err_m), 32'h1);
    check("parity drop keeps dout", 32'(dout_m), 32'hA5);
    drain();
    send_frame(8'h01, 1'b1, 1'b0);
    check("parity 01 perr", 32'(parity_err_m), 32'h0);
    check("parity 01 dout", 32'(dout_m), 32'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-to-parallel deserializer placed directly downstream of the single-bit D flip-flop stage.
- Consumes the registered serial bit (flip-flop q) one bit per qualifying clock edge and assembles WIDTH-bit words.
- Presents each completed word on a valid/ready output handshake, with one word of output buffering and sticky overrun detection.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- din  input  1  serial data bit, driven from the upstream flip-flop q.
- din_valid  input  1  bit strobe; din is sampled only when din_valid=1.
- dout  output  WIDTH  assembled word, registered.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1 at a posedge.
- overrun  output  1  sticky flag: a completed word was dropped.
- parity_err  output  1  parity error for the word on dout (see Optional Feature).

Behaviour:
- Reset (reset=1 at posedge): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, parity_err=0.
- Reset wins over every other event, including a word completing in the same cycle.
- Reset mid-word discards the partial word; the next accepted bit is bit 0 of a new frame.
- Bit accept: din_valid=1 shifts din into the shift register and increments bit_cnt. No backpressure toward din; bits are always accepted.
- Shift direction:
  - MSB_FIRST=1: shift left, din enters at LSB.
  - MSB_FIRST=0: shift right, din enters at MSB.
- Frame length FL = WIDTH, or WIDTH+1 with PARITY_EN.
- Word completion occurs on the accepted bit with bit_cnt = FL-1. bit_cnt wraps to 0 on that edge, and the next bit starts a new frame with no idle gap.
- Latency: dout and dout_valid update on the same posedge that samples the final bit, so dout_valid is visible in the cycle after the final bit's strobe.
- Output slot update at a completion edge:
  - Slot empty (dout_valid=0): load dout, set dout_valid=1.
  - Slot consumed this edge (dout_valid=1 and dout_ready=1): load the new word, dout_valid stays 1, no overrun.
  - Slot full and not consumed (dout_valid=1 and dout_ready=0): drop the new word, dout retains the old word, set overrun=1.
- Handshake with no completion: dout_valid=1 and dout_ready=1 clears dout_valid. dout keeps its last value.
- dout_ready is ignored when dout_valid=0.
- overrun remains 1 until reset.
- din_valid=0 freezes the shift register and bit_cnt indefinitely; there is no timeout.
- While dout_valid=1 and dout_ready=0, dout must not change (stability requirement for verification).

Optional Feature:
- Macro PARITY_EN.
- When defined:
  - Frame is WIDTH data bits followed by one even-parity bit.
  - At completion, parity_err = XOR of the WIDTH data bits and the parity bit. This gives 1 when the total count of ones is odd.
  - parity_err is loaded together with dout and follows the same drop and hold rules as dout.
  - The parity bit never appears in dout.
- When not defined: frame is WIDTH bits, and parity_err is constant 0.

Test Plan:
- Reset check: hold reset=1 for 2 cycles with din_valid=1, din=1 -> dout=0x00, dout_valid=0, overrun=0, and bit_cnt stays 0 after release.
- Basic word (WIDTH=8, MSB_FIRST=1): strobe bits 1,0,1,0,0,1,0,1 on consecutive cycles with dout_ready=0 -> dout=0xA5, dout_valid=1 one cycle after the 8th strobe. Raising dout_ready for 1 cycle clears dout_valid, and dout stays 0xA5.
- Back-to-back with concurrent handshake: stream 0x3C then 0xC3 continuously, with dout_ready=1 only on the edge where 0xC3 completes -> dout changes from 0x3C to 0xC3, dout_valid stays 1, overrun=0.
- Overrun: send 0x11 then 0x22 with dout_ready=0 throughout -> dout stays 0x11, dout_valid=1, overrun=1. The flag persists after a later handshake and clears only on reset.
- Gaps and mid-word reset:
  - Send bits of 0x0F with random din_valid gaps -> dout=0x0F.
  - Send 4 bits of 0xFF, pulse reset, then send 0x81 -> dout=0x81 and no trace of the partial word.
- LSB-first and parity:
  - MSB_FIRST=0: bits 1,0,1,0,0,1,0,1 -> dout=0xA5.
  - With PARITY_EN, send 0xA5 (four ones) then parity bit 0 -> parity_err=0.
  - Send 0xA5 then parity bit 1 -> parity_err=1, and dout still 0xA5.
